writeback_scheduler: RTL and testbench
======================================

# writeback_scheduler

Owns the single write port of `register_file` and shares it between the two writeback sources, ALU and memory load, using a 2-way round-robin arbiter with valid/ready handshakes. Also keeps a 32-bit busy scoreboard of destination registers with outstanding writes, reserved at issue and released when the write lands. Decode uses the scoreboard to stall on RAW/WAW hazards. Sits between the execute/memory stages and `register_file`; its `wb_en`/`wb_rd`/`wb_data` outputs drive `en`/`rd`/`data` directly.

## Interface
- `WORD_SIZE`, 32, data width of register file words.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `iss_valid`  in  1  decode is issuing an instruction this cycle.
- `iss_rd`  in  5  destination register of issuing instruction.
- `iss_rs1`, `iss_rs2`  in  5 each  source registers of issuing instruction.
- `hazard`  out  1  combinational; issue must stall.
- `alu_valid`  in  1  ALU writeback request.
- `alu_rd`  in  5  ALU destination.
- `alu_data`  in  WORD_SIZE  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`, `mem_rd`, `mem_data`, `mem_ready`: same roles for the load path.
- `wb_en`  out  1  register file write enable.
- `wb_rd`  out  5  register file write address.
- `wb_data`  out  WORD_SIZE  register file write data.
- `busy`  out  32  scoreboard; bit n set means register n has a write outstanding.

## Operation
- Hazard: `hazard = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd])`. `busy[0]` is constant 0, so x0 never hazards.
- Reserve: at a posedge with `iss_valid & ~hazard & iss_rd != 0`, set `busy[iss_rd]`.
- Arbitration:
  - Only one valid: that source is granted.
  - Both valid: grant the source not granted last. `last_grant` resets to MEM, so ALU wins the first tie.
  - `last_grant` updates only on an accepted transfer.
  - `alu_ready` and `mem_ready` are never both 1. A ready is never 1 without its valid.
- Requester rule: once `valid` is high, `rd` and `data` stay stable until ready. Valid does not drop before acceptance. Violation is a bench assertion.
- Accept: at a posedge with `x_valid & x_ready`, register `wb_rd <= x_rd`, `wb_data <= x_data`, and `wb_en <= (x_rd != 0)`. With no accept, `wb_en <= 0`; `wb_rd` and `wb_data` hold.
- Release: at a posedge with `wb_en`, clear `busy[wb_rd]`.
- Set and clear of the same bit in one edge cannot occur, because reserve requires the bit clear. If it does occur, set wins, and a bench assertion flags it.
- Writeback of a register that is not busy is legal: the write happens and the busy bit stays clear.

## Timing
- Reset (asynchronous, immediate): `busy = 0`, `wb_en = 0`, `wb_rd = 0`, `wb_data = 0`, `last_grant = MEM`.
  - Outputs `hazard`, `alu_ready` and `mem_ready` follow from inputs and cleared state.
  - Reset mid-operation drops any accepted-but-unwritten result. Upstream is reset together with this block.
- `hazard`, `alu_ready` and `mem_ready` are combinational with no path through `wb_*`.
- Latency, accept at edge N:
  - `wb_en` is high in cycle N→N+1.
  - Register file writes at edge N+1, and `busy` clears at edge N+1.
  - `hazard` for that register drops in the cycle after edge N+1. The combinational read then already returns the new value, so no forwarding is needed.
- Throughput: one writeback per cycle. With both sources continuously valid, grants alternate every cycle.
- Reserve at edge M: `hazard` for that register rises in cycle M→M+1.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W = 5`, `NUM_REGS = 32`.
  - Source enum `SRC_ALU = 0`, `SRC_MEM = 1`.
  - Type for register address.
- Sub-module `rr_arbiter2`:
  - Inputs: `clk`, `rst`, `req[1:0]`.
  - Outputs: `gnt[1:0]` one-hot or zero.
  - Internal `last_grant` flop, updated when any gnt is high.
- Scoreboard, hazard logic and writeback register are inline in `writeback_scheduler`.
- Target size is about 150–250 lines.

## Test plan
- Reset then idle: `busy = 0`, `wb_en = 0`, `hazard = 0` for any `iss_*`; assert `rst` low mid-burst and all state clears immediately.
- Issue with `rd = 5` at edge 1. Then `iss_rs1 = 5` gives `hazard = 1`. ALU writes `rd = 5`, `data = 0xDEADBEEF` accepted at edge 3. Then `wb_en = 1`, `wb_rd = 5` in cycle 3–4, `busy[5] = 0` after edge 4, `hazard = 0`, and the register file reads `0xDEADBEEF`.
- ALU and MEM both valid for 4 cycles with distinct rd: grants go ALU, MEM, ALU, MEM, and `wb_rd` sequence matches.
- Only MEM valid with ALU idle: MEM granted every cycle; after ALU becomes valid concurrently, ALU wins next.
- Writeback to `rd = 0` with `data = 0xFFFFFFFF`: accepted (`ready = 1`), `wb_en` stays 0, `busy[0]` stays 0; issue with `rd = 0` and `rs1 = 0` gives no hazard.
- WAW: issue `rd = 7`, then reissue `rd = 7` before writeback. `hazard = 1` until the cycle after the write lands, then the second issue reserves `busy[7]` again.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address width, register count and writeback source ids.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: bit 0 is ALU, bit 1 is MEM; ties go to the side not granted last.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    src_e last_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == SRC_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_q <= SRC_MEM;
        else if (|gnt)
            last_q <= gnt[1] ? SRC_MEM : SRC_ALU;
    end
endmodule

// File: rtl/writeback_scheduler.sv
// Arbitrates ALU/load writebacks onto the single register-file write port and keeps the
// busy scoreboard that decode uses to stall on RAW/WAW hazards.
module writeback_scheduler
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_valid,
    input  reg_addr_t            iss_rd,
    input  reg_addr_t            iss_rs1,
    input  reg_addr_t            iss_rs2,
    output logic                 hazard,
    input  logic                 alu_valid,
    input  reg_addr_t            alu_rd,
    input  logic [WORD_SIZE-1:0] alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  reg_addr_t            mem_rd,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic                 mem_ready,
    output logic                 wb_en,
    output reg_addr_t            wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic [NUM_REGS-1:0]  busy
);
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic                 wb_en_q;
    reg_addr_t            wb_rd_q;
    logic [WORD_SIZE-1:0] wb_data_q;
    logic [1:0]           gnt;
    logic                 reserve;
    reg_addr_t            sel_rd;
    logic [WORD_SIZE-1:0] sel_data;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({mem_valid, alu_valid}),
        .gnt (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign sel_rd    = gnt[1] ? mem_rd   : alu_rd;
    assign sel_data  = gnt[1] ? mem_data : alu_data;

    assign hazard  = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
    assign reserve = iss_valid & ~hazard & (iss_rd != '0);

    // Release first so a same-edge reserve of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_q)
            busy_d[wb_rd_q] = 1'b0;
        if (reserve)
            busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            busy_q  <= busy_d;
            wb_en_q <= (|gnt) && (sel_rd != '0);
            if (|gnt) begin
                wb_rd_q   <= sel_rd;
                wb_data_q <= sel_data;
            end
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_writeback_scheduler.sv
// Directed bench: expected writebacks are queued at issue time and checked by a monitor.
module tb_writeback_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
    logic        hazard;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];

    writeback_scheduler #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .hazard(hazard),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // exp_src: 0 = ALU granted, 1 = MEM granted, 2 = nothing granted
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input int exp_src);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, exp_src == 0});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, exp_src == 1});
        if (exp_src == 0 && ard != 5'd0) exp_q.push_back('{ard, ad});
        if (exp_src == 1 && mrd != 5'd0) exp_q.push_back('{mrd, md});
        cyc();
    endtask

    // Monitor: every write-port pulse must match the oldest expected writeback.
    always @(negedge clk) begin
        if (rst && wb_en) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {27'd0, wb_rd}, 32'hFFFF_FFFF);
            end else begin
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp_q[0].rd});
                chk("wb_data", wb_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // Requester rule: a pending request holds valid, rd and data until accepted.
    logic        alu_pend = 1'b0, mem_pend = 1'b0;
    logic [36:0] alu_hold = '0, mem_hold = '0;
    always @(posedge clk) begin
        if (!rst) begin
            alu_pend <= 1'b0;
            mem_pend <= 1'b0;
        end else begin
            if (alu_pend) chk("alu_stable", {26'd0, alu_valid, alu_rd}, {26'd0, 1'b1, alu_hold[36:32]});
            if (alu_pend) chk("alu_data_stable", alu_data, alu_hold[31:0]);
            if (mem_pend) chk("mem_stable", {26'd0, mem_valid, mem_rd}, {26'd0, 1'b1, mem_hold[36:32]});
            if (mem_pend) chk("mem_data_stable", mem_data, mem_hold[31:0]);
            alu_pend <= alu_valid & ~alu_ready;
            mem_pend <= mem_valid & ~mem_ready;
            alu_hold <= {alu_rd, alu_data};
            mem_hold <= {mem_rd, mem_data};
            if (iss_valid && !hazard && iss_rd != 5'd0 && wb_en && wb_rd == iss_rd)
                chk("set_clear_collision", {27'd0, iss_rd}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd3; iss_rs2 = 5'd4;
        #1 chk("rst_hazard", {31'd0, hazard}, 32'd0);
        iss_valid = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // Reserve rd=5, RAW hazard, ALU writeback of 0xDEADBEEF releases it
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1 chk("t2_hazard_pre", {31'd0, hazard}, 32'd0);
        cyc();
        iss_rd = 5'd0; iss_rs1 = 5'd5;
        #1;
        chk("t2_hazard_raw", {31'd0, hazard}, 32'd1);
        chk("t2_busy5", busy, 32'h0000_0020);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 0);
        alu_valid = 1'b0;
        #1;
        chk("t2_wb_en", {31'd0, wb_en}, 32'd1);
        chk("t2_hazard_inflight", {31'd0, hazard}, 32'd1);
        cyc();
        #1;
        chk("t2_busy_clear", busy, 32'd0);
        chk("t2_hazard_clear", {31'd0, hazard}, 32'd0);
        iss_valid = 1'b0; iss_rs1 = 5'd0;

        // MEM alone gets every grant; then ALU joins and wins the tie
        drive(1'b0, 5'd0,  32'd0,        1'b1, 5'd12, 32'h1200_0012, 1);
        drive(1'b0, 5'd0,  32'd0,        1'b1, 5'd13, 32'h1300_0013, 1);
        drive(1'b1, 5'd22, 32'h2200_0022, 1'b1, 5'd14, 32'h1400_0014, 0);
        drive(1'b0, 5'd0,  32'd0,        1'b1, 5'd14, 32'h1400_0014, 1);

        // Both valid: alternation ALU, MEM, ALU, MEM
        drive(1'b1, 5'd10, 32'hA000_0010, 1'b1, 5'd20, 32'hB000_0020, 0);
        drive(1'b1, 5'd11, 32'hA000_0011, 1'b1, 5'd20, 32'hB000_0020, 1);
        drive(1'b1, 5'd11, 32'hA000_0011, 1'b1, 5'd21, 32'hB000_0021, 0);
        drive(1'b1, 5'd16, 32'hA000_0016, 1'b1, 5'd21, 32'hB000_0021, 1);
        drive(1'b1, 5'd16, 32'hA000_0016, 1'b0, 5'd0,  32'd0,        0);
        drive(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        2);

        // Writeback to x0 is accepted but never enables the port
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 0);
        alu_valid = 1'b0;
        #1;
        chk("x0_wb_en", {31'd0, wb_en}, 32'd0);
        chk("x0_busy", busy, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1 chk("x0_hazard", {31'd0, hazard}, 32'd0);
        cyc();
        chk("x0_no_reserve", busy, 32'd0);

        // WAW on rd=7: second issue stalls until the write has landed, then reserves
        iss_rd = 5'd7;
        #1 chk("waw_first", {31'd0, hazard}, 32'd0);
        cyc();
        #1 chk("waw_stall", {31'd0, hazard}, 32'd1);
        drive(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 32'd0, 0);
        alu_valid = 1'b0;
        #1 chk("waw_stall_wb", {31'd0, hazard}, 32'd1);
        cyc();
        #1 chk("waw_release", {31'd0, hazard}, 32'd0);
        cyc();
        #1 chk("waw_rereserve", busy, 32'h0000_0080);
        iss_valid = 1'b0; iss_rd = 5'd0;
        drive(1'b1, 5'd7, 32'h0000_0078, 1'b0, 5'd0, 32'd0, 0);
        drive(1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0, 2);
        #1 chk("waw_final_busy", busy, 32'd0);

        // Reset mid-burst drops the accepted result and clears all state
        iss_valid = 1'b1; iss_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044;
        cyc();
        iss_rd = 5'd0; iss_rs1 = 5'd9;
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        chk("mid_rst_hazard", {31'd0, hazard}, 32'd0);
        chk("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        iss_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc(); cyc(); cyc();
        chk("exp_q_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
